// File: rtl/hs_npu_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : hs_npu_result_writer
// Description : Drains the per-lane output FIFOs one complete row at a time.
//               Each row is packed into BUS_WIDTH-bit words and written out
//               as address-incrementing beats on a valid/ready channel. The
//               block runs a programmed number of rows per job and then
//               pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_npu_result_writer #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 16,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    input  logic [31:0]                          num_rows,
    output logic                                 busy,
    output logic                                 done,
    input  logic [SIZE-1:0][DATA_WIDTH-1:0]      result_i,
    input  logic [SIZE-1:0]                      result_valid_i,
    output logic                                 result_ready_o,
    output logic                                 wr_valid_o,
    input  logic                                 wr_ready_i,
    output logic [ADDR_WIDTH-1:0]                wr_addr_o,
    output logic [BUS_WIDTH-1:0]                 wr_data_o
);

    // Beats per row, and the width of the word index that walks them.
    localparam int c_WORDS = (SIZE * DATA_WIDTH) / BUS_WIDTH;
    localparam int c_IDX_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX  = c_IDX_W'(c_WORDS - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_ONE   = c_IDX_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_STEP = ADDR_WIDTH'(BUS_WIDTH / 8);
    localparam logic [31:0]           c_ONE_ROW   = 32'd1;

    // State encoding.
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT_ROW = 2'd1;
    localparam logic [1:0] c_SEND     = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    logic [1:0]                           r_state;
    logic [1:0]                           w_state_nxt;
    logic [ADDR_WIDTH-1:0]                r_addr;
    logic [31:0]                          r_rows_left;
    logic [c_IDX_W-1:0]                   r_word_idx;
    // Row buffer viewed as bus words: word 0 holds lanes 0.. in its LSBs.
    logic [c_WORDS-1:0][BUS_WIDTH-1:0]    r_row_buf;

    logic w_all_valid;
    logic w_accept_start;
    logic w_pop;
    logic w_beat;
    logic w_last_beat;

    // Handshake qualifiers; abort overrides every transfer in its cycle so
    // that neither the FIFOs nor the internal counters move.
    always_comb begin
        w_all_valid    = &result_valid_i;
        w_accept_start = (r_state == c_IDLE) && start && !abort;
        w_pop          = (r_state == c_WAIT_ROW) && w_all_valid && !abort;
        w_beat         = (r_state == c_SEND) && wr_ready_i && !abort;
        w_last_beat    = w_beat && (r_word_idx == c_LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort wins over everything else.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_rows == 32'd0) ? c_DONE : c_WAIT_ROW;
                end
            end
            c_WAIT_ROW: begin
                if (w_all_valid) begin
                    w_state_nxt = c_SEND;
                end
            end
            c_SEND: begin
                if (wr_ready_i && (r_word_idx == c_LAST_IDX)) begin
                    w_state_nxt = (r_rows_left == c_ONE_ROW) ? c_DONE : c_WAIT_ROW;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
        if (abort) begin
            w_state_nxt = c_IDLE;
        end
    end

    // Job registers: address, remaining rows, word index and captured row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_rows_left <= '0;
            r_word_idx  <= '0;
            r_row_buf   <= '0;
        end else begin
            if (w_accept_start) begin
                r_addr      <= base_addr;
                r_rows_left <= num_rows;
            end
            if (w_pop) begin
                r_row_buf  <= result_i;
                r_word_idx <= '0;
            end
            if (w_beat) begin
                // Address wraps naturally at 2^ADDR_WIDTH.
                r_addr     <= r_addr + c_ADDR_STEP;
                r_word_idx <= r_word_idx + c_IDX_ONE;
            end
            if (w_last_beat) begin
                r_rows_left <= r_rows_left - c_ONE_ROW;
            end
        end
    end

    // Outputs are decoded from state so they are all zero straight after reset.
    always_comb begin
        busy           = (r_state != c_IDLE);
        done           = (r_state == c_DONE);
        result_ready_o = w_pop;
        wr_valid_o     = (r_state == c_SEND);
        wr_addr_o      = r_addr;
        wr_data_o      = (r_state == c_SEND) ? r_row_buf[r_word_idx] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_hs_npu_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_npu_result_writer
// Description : Randomised scoreboard bench for hs_npu_result_writer. Jobs
//               push their expected beats into a queue; a monitor pops and
//               compares on every accepted write beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_npu_result_writer;

    localparam int SIZE  = 8;
    localparam int DW    = 16;
    localparam int BW    = 32;
    localparam int AW    = 32;
    localparam int WORDS = SIZE * DW / BW;
    localparam int LPW   = BW / DW;

    typedef logic [SIZE-1:0][DW-1:0] row_t;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] d;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    logic [AW-1:0]           base_addr = '0;
    logic [31:0]             num_rows = '0;
    logic                    busy;
    logic                    done;
    logic [SIZE-1:0][DW-1:0] result_i;
    logic [SIZE-1:0]         result_valid_i;
    logic                    result_ready_o;
    logic                    wr_valid_o;
    logic                    wr_ready_i;
    logic [AW-1:0]           wr_addr_o;
    logic [BW-1:0]           wr_data_o;

    hs_npu_result_writer #(
        .SIZE(SIZE), .DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .num_rows(num_rows), .busy(busy), .done(done),
        .result_i(result_i), .result_valid_i(result_valid_i),
        .result_ready_o(result_ready_o), .wr_valid_o(wr_valid_o),
        .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    row_t  row_q[$];
    beat_t exp_q[$];
    int    valid_pct  = 100;
    int    ready_mode = 0;
    int    hold7      = 0;
    int    rpat       = 0;
    int    pops       = 0;
    int    hs_cnt     = 0;
    int    last_hs    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s", msg);
    endtask

    // Lane FIFO heads and write-channel ready; lanes show garbage when invalid.
    initial begin : driver
        bit pop;
        logic v;
        result_i       = '0;
        result_valid_i = '0;
        wr_ready_i     = 1'b0;
        forever begin
            @(negedge clk);
            pop = result_ready_o;
            @(posedge clk);
            #1;
            if (pop && row_q.size() > 0) void'(row_q.pop_front());
            case (ready_mode)
                0:       wr_ready_i = 1'b1;
                1:       wr_ready_i = 1'($urandom_range(0, 1));
                default: begin
                    wr_ready_i = (rpat >= 2) && (((rpat - 2) % 2) == 0);
                    rpat++;
                end
            endcase
            for (int k = 0; k < SIZE; k++) begin
                v = (row_q.size() > 0) && (int'($urandom_range(0, 99)) < valid_pct)
                    && !((k == SIZE - 1) && (hold7 > 0));
                result_valid_i[k] = v;
                result_i[k]       = v ? row_q[0][k] : DW'($urandom);
            end
            if (hold7 > 0) hold7--;
        end
    end

    // Monitor: pops the scoreboard on every accepted beat, checks stall stability.
    initial begin : monitor
        beat_t e;
        beat_t prev;
        bit    stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (result_ready_o) begin
                    pops++;
                    chk("pop_has_row", 64'(row_q.size() > 0), 64'd1);
                end
                if (stalled) begin
                    chk("stall_valid", 64'(wr_valid_o), 64'd1);
                    chk("stall_addr", 64'(wr_addr_o), 64'(prev.a));
                    chk("stall_data", 64'(wr_data_o), 64'(prev.d));
                end
                stalled = 1'b0;
                if (wr_valid_o) begin
                    if (wr_ready_i) begin
                        hs_cnt++;
                        last_hs = cyc;
                        if (exp_q.size() == 0) begin
                            $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h, expected none",
                                     wr_addr_o, wr_data_o);
                            vectors++;
                            miscompares++;
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat_addr", 64'(wr_addr_o), 64'(e.a));
                            chk("beat_data", 64'(wr_data_o), 64'(e.d));
                        end
                    end else if (!abort) begin
                        stalled = 1'b1;
                        prev.a  = wr_addr_o;
                        prev.d  = wr_data_o;
                    end
                end
            end
        end
    end

    // Reference model: rows in order, word w of row r at base + BW/8*(r*WORDS+w),
    // lane w*LPW+j occupying bits [j*DW +: DW] of that word.
    task automatic load_job(input int nrows, input logic [AW-1:0] base, input bit fixed);
        row_t  r;
        beat_t b;
        for (int i = 0; i < nrows; i++) begin
            for (int k = 0; k < SIZE; k++) r[k] = fixed ? DW'(16'h0010 + k) : DW'($urandom);
            row_q.push_back(r);
            for (int w = 0; w < WORDS; w++) begin
                b.a = base + AW'((i * WORDS + w) * (BW / 8));
                for (int j = 0; j < LPW; j++) b.d[j*DW +: DW] = r[w*LPW + j];
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic pulse_start(input int nrows, input logic [AW-1:0] base, output int ts);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        num_rows  = 32'(nrows);
        ts        = cyc;
    endtask

    task automatic run_job(input int nrows, input logic [AW-1:0] base, input int hold,
                           input bit fixed, input bit poke);
        int ts;
        int p0;
        int limit;
        bit seen;
        load_job(nrows, base, fixed);
        p0 = pops;
        pulse_start(nrows, base, ts);
        @(negedge clk);
        hold7 = hold;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = $urandom;
        num_rows  = $urandom;
        seen  = 1'b0;
        limit = 60 + nrows * 100 + hold;
        for (int c = 0; c < limit && !seen; c++) begin
            @(negedge clk);
            if (c == 0) chk("busy_after_start", 64'(busy), 64'd1);
            if (hold > 0 && c < hold) chk("partial_no_pop", 64'(result_ready_o), 64'd0);
            if (hold > 0 && c == hold) chk("partial_pop", 64'(result_ready_o), 64'd1);
            if (poke && c == 1) begin
                chk("poke_in_send", 64'(wr_valid_o), 64'd1);
                start     = 1'b1;
                num_rows  = 32'd1;
                base_addr = 32'hDEAD_0000;
            end
            if (poke && c == 2) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                if (nrows == 0) chk("done_cycle_zero", 64'(cyc), 64'(ts + 1));
                else            chk("done_cycle", 64'(cyc), 64'(last_hs + 1));
            end
        end
        if (!seen) begin
            fail($sformatf("done_timeout: got no done in %0d cycles, expected one", limit));
        end else begin
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("busy_cleared", 64'(busy), 64'd0);
        end
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        chk("pop_count", 64'(pops - p0), 64'(nrows));
        exp_q.delete();
        row_q.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_ready"}, 64'(result_ready_o), 64'd0);
        chk({tag, "_wr_valid"}, 64'(wr_valid_o), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr_o), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data_o), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int ts;
        int h0;
        int p0;
        bit found;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single row with fixed lane values.
        ready_mode = 0;
        valid_pct  = 100;
        run_job(1, 32'h1000, 0, 1'b1, 1'b0);

        // Lane 7 withheld for five cycles.
        run_job(1, 32'h1800, 5, 1'b0, 1'b0);

        // Backpressure pattern 0,0,1,0,1,... over three rows.
        @(negedge clk);
        rpat       = 0;
        ready_mode = 2;
        run_job(3, 32'h1000, 0, 1'b0, 1'b0);
        ready_mode = 0;

        // Zero rows.
        run_job(0, 32'h4000, 0, 1'b0, 1'b0);

        // Start pulsed during SEND must not change the job.
        run_job(3, 32'h6000, 0, 1'b0, 1'b1);

        // Abort after two beats of the first row.
        load_job(2, 32'h2000, 1'b0);
        h0 = hs_cnt;
        p0 = pops;
        pulse_start(2, 32'h2000, ts);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 40 && (hs_cnt - h0) < 2; c++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_precond_beats", 64'(hs_cnt - h0), 64'd2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_wr_valid", 64'(wr_valid_o), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_done", 64'(done), 64'd0);
        end
        chk("abort_pops", 64'(pops - p0), 64'd1);
        exp_q.delete();
        row_q.delete();
        run_job(2, 32'h5000, 0, 1'b0, 1'b0);

        // Reset in the middle of SEND.
        load_job(2, 32'h3000, 1'b0);
        pulse_start(2, 32'h3000, ts);
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            found = wr_valid_o;
        end
        chk("reset_precond_send", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_outputs_zero("midsend_reset");
        exp_q.delete();
        row_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised jobs with random backpressure and lane validity,
        // including one that wraps the address space.
        ready_mode = 1;
        valid_pct  = 80;
        run_job(2, 32'hFFFF_FFF0, 0, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(1, 4)), AW'($urandom), 0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hs_npu_result_writer.md
# hs_npu_result_writer

Downstream stage of the inference datapath. Drains the SIZE per-lane output FIFOs one complete row at a time. Packs each row of activation results into BUS_WIDTH-bit words and issues them as sequential, address-incrementing write beats on a valid/ready write channel toward memory. Runs a programmed number of rows per job, then reports completion to the controller.

## Interface
- SIZE, 8: lanes per row (systolic array columns)
- DATA_WIDTH, 16: bits per activation result
- BUS_WIDTH, 32: write data width; SIZE*DATA_WIDTH must be a multiple of BUS_WIDTH, and BUS_WIDTH a multiple of DATA_WIDTH
- ADDR_WIDTH, 32: write address width
- WORDS (derived), SIZE*DATA_WIDTH/BUS_WIDTH: beats per row (4 at defaults)

- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  pulse; latches base_addr and num_rows when idle
- abort  in  1  synchronous job cancel
- base_addr  in  ADDR_WIDTH  byte address of the first beat
- num_rows  in  32 (uword)  rows in this job
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- result_i  in  [SIZE] x DATA_WIDTH  output FIFO heads
- result_valid_i  in  [SIZE] x 1  per-lane output FIFO valid
- result_ready_o  out  1  shared pop strobe to all output FIFOs
- wr_valid_o  out  1  write beat valid
- wr_ready_i  in  1  write beat accepted
- wr_addr_o  out  ADDR_WIDTH  byte address of the beat
- wr_data_o  out  BUS_WIDTH  beat data

## Operation
- FSM states: IDLE, WAIT_ROW, SEND, DONE.
- IDLE:
  - start=1 latches addr<=base_addr, rows_left<=num_rows.
  - Next state is WAIT_ROW, or DONE if num_rows==0.
- WAIT_ROW:
  - result_ready_o=1 combinationally only when every result_valid_i[k] is 1.
  - In that cycle, capture all SIZE lanes into row_buf, set word_idx<=0, and go to SEND.
  - With partial valid, nothing is popped and the state is held.
- SEND:
  - wr_valid_o=1, wr_data_o = row_buf bits [word_idx*BUS_WIDTH +: BUS_WIDTH].
  - Packing: lane 0 sits in the LSBs of word 0, and lanes ascend.
  - On wr_valid_o && wr_ready_i: addr += BUS_WIDTH/8 and word_idx++.
  - On the last word (word_idx==WORDS-1): rows_left--. Go to DONE if rows_left==1, else go to WAIT_ROW.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in WAIT_ROW, SEND and DONE.
- start is ignored while not in IDLE.
- abort=1 in any state forces IDLE next cycle:
  - clears wr_valid_o and done;
  - a row already popped is discarded;
  - FIFO contents are untouched (the controller flushes them).
- abort has priority over start and over handshakes in the same cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is flagged.
- Data is passed bit-exact; there is no sign extension or saturation.

## Timing
- Reset (rst_n=0 at a clk edge), all outputs 0:
  - busy=0, done=0, result_ready_o=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0.
  - State becomes IDLE and internal counters clear.
- start accepted at edge t: busy=1 from t+1, and the state is WAIT_ROW from t+1.
- Row pop at cycle c (result_ready_o=1): the first beat is valid at c+1.
- With wr_ready_i held high, one beat is issued per cycle. Each row therefore costs WORDS+1 cycles: 1 pop + WORDS beats.
- wr_addr_o and wr_data_o are stable while wr_valid_o=1 && wr_ready_i=0.
- wr_valid_o never drops without a handshake, except on abort or reset.
- The last beat is accepted at cycle e: next cycle is WAIT_ROW (more rows) or DONE, so done=1 at e+1 and busy=0 at e+2.
- num_rows==0: start at t gives done=1 at t+1 and no pops or beats.
- result_ready_o is never asserted outside WAIT_ROW, so there are no pops while beats are pending.

## Test plan
- Single row:
  - Stimulus: num_rows=1, base_addr=0x1000, lanes k=0..7 hold 0x0010+k, all valid, wr_ready_i=1.
  - Response: one pop; beats 0x1000:0x00110010, 0x1004:0x00130012, 0x1008:0x00150014, 0x100C:0x00170016; done one cycle after the last beat.
- Partial valid:
  - Stimulus: lanes 0..6 valid, lane 7 invalid for 5 cycles, then valid.
  - Response: result_ready_o stays 0 for 5 cycles, then a single pop; data is correct.
- Backpressure:
  - Stimulus: wr_ready_i toggles 0,0,1,0,1,... over 3 rows.
  - Response: no beat lost or duplicated; addresses run 0x1000..0x102C contiguous; data/addr stable while stalled.
- Zero rows: num_rows=0 -> done at t+1, no pops, no wr_valid_o.
- Abort mid-row:
  - Stimulus: abort asserted after 2 of 4 beats accepted.
  - Response: IDLE next cycle, wr_valid_o=0, no done. A new start with fresh base_addr then runs correctly.
- Reset and start while busy:
  - Stimulus (reset): rst_n=0 mid-SEND.
  - Response: all outputs 0 next cycle.
  - Stimulus (start while busy): start pulsed during SEND.
  - Response: ignored; the row count is unchanged.
